// File: rtl/accum_multi.sv
// accum_multi
//   Multi-mode reduction unit. It collects a group of 1..p_max_nmsgs messages
//   through a val/rdy request port. It reduces the group with an operator chosen
//   per group and returns one result per group through a val/rdy response port.
//
//   Operators (cfg_op, sampled on the first message of a group):
//     00 wrapping add    (ovf = any carry-out)
//     01 signed max      (ovf stays 0)
//     10 signed min      (ovf stays 0)
//     11 unsigned saturating add (ovf = any clamp)
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   req_val/req_rdy     request handshake
//   req_msg             operand
//   req_last            closes the current group after this message
//   cfg_op, cfg_nmsgs   group operator and size (first message only)
//   resp_val/resp_rdy   response handshake
//   resp_msg            reduced result
//   resp_count          number of messages reduced into resp_msg
//   resp_ovf            overflow seen anywhere in the group
module accum_multi #(
  parameter int p_width     = 16,
  parameter int p_max_nmsgs = 8,
  parameter int p_cnt_width = $clog2(p_max_nmsgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [p_width-1:0]     req_msg,
  input  logic                   req_last,
  input  logic [1:0]             cfg_op,
  input  logic [p_cnt_width-1:0] cfg_nmsgs,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [p_width-1:0]     resp_msg,
  output logic [p_cnt_width-1:0] resp_count,
  output logic                   resp_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;
  localparam logic [1:0] OP_SAT = 2'b11;

  localparam logic [p_cnt_width-1:0] MAX_N   = p_cnt_width'(p_max_nmsgs);
  localparam logic [p_cnt_width-1:0] CNT_ONE = p_cnt_width'(1);

  // Unsigned add with the carry kept as the extra top bit.
  function automatic logic [p_width:0] add_wide(input logic [p_width-1:0] a,
                                                input logic [p_width-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Clamp a carried sum to all-ones when the carry bit is set.
  function automatic logic [p_width-1:0] sat_unsigned(input logic [p_width:0] s);
    return s[p_width] ? {p_width{1'b1}} : s[p_width-1:0];
  endfunction

  // Group size 0 means 1; sizes above the maximum are clamped to the maximum.
  function automatic logic [p_cnt_width-1:0] clamp_n(input logic [p_cnt_width-1:0] c);
    if (c == '0)       return CNT_ONE;
    else if (c > MAX_N) return MAX_N;
    else               return c;
  endfunction

  state_t                   state, state_next;
  logic [1:0]               op_q;
  logic [p_cnt_width-1:0]   n_q;
  logic [p_width-1:0]       acc_q;
  logic [p_cnt_width-1:0]   count_q;
  logic                     ovf_q;

  logic                     req_go, resp_go;
  logic                     first;
  logic                     close;
  logic [p_cnt_width-1:0]   n_use;
  logic [p_cnt_width-1:0]   cnt_next;
  logic [p_width:0]         sum_w;
  logic signed [p_width-1:0] acc_s, msg_s;
  logic [p_width-1:0]       acc_next;
  logic                     ovf_next;

  assign req_go  = req_val & req_rdy;
  assign resp_go = resp_val & resp_rdy;
  assign acc_s   = acc_q;
  assign msg_s   = req_msg;

  // Accepted-message datapath: a message opens a group unless one is already open.
  // A handshake in DONE is only possible together with resp_go.
  always_comb begin
    first    = req_go & (state != S_ACCUM);
    n_use    = first ? clamp_n(cfg_nmsgs) : n_q;
    cnt_next = first ? CNT_ONE : count_q + CNT_ONE;
    close    = req_go & ((cnt_next == n_use) | req_last);
    sum_w    = add_wide(acc_q, req_msg);
    acc_next = acc_q;
    ovf_next = ovf_q;
    if (first) begin
      acc_next = req_msg;
      ovf_next = 1'b0;
    end else begin
      case (op_q)
        OP_ADD: begin
          acc_next = sum_w[p_width-1:0];
          ovf_next = ovf_q | sum_w[p_width];
        end
        OP_MAX: if (msg_s > acc_s) acc_next = req_msg;
        OP_MIN: if (msg_s < acc_s) acc_next = req_msg;
        OP_SAT: begin
          acc_next = sat_unsigned(sum_w);
          ovf_next = ovf_q | sum_w[p_width];
        end
        default: acc_next = acc_q;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    if (req_go)       state_next = close ? S_DONE : S_ACCUM;
    else if (resp_go) state_next = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    resp_val = (state == S_DONE);
    req_rdy  = (state != S_DONE) | resp_rdy;
  end

  // Group registers: written only on an accepted message, so the held result
  // stays stable under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      n_q     <= CNT_ONE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (req_go) begin
      if (first) begin
        op_q <= cfg_op;
        n_q  <= n_use;
      end
      acc_q   <= acc_next;
      count_q <= cnt_next;
      ovf_q   <= ovf_next;
    end
  end

  assign resp_msg   = acc_q;
  assign resp_count = count_q;
  assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_accum_multi.sv
module tb_accum_multi;

  localparam int W  = 8;
  localparam int MX = 8;
  localparam int CW = $clog2(MX + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val, req_rdy, req_last;
  logic [W-1:0]  req_msg;
  logic [1:0]    cfg_op;
  logic [CW-1:0] cfg_nmsgs;
  logic          resp_val, resp_rdy;
  logic [W-1:0]  resp_msg;
  logic [CW-1:0] resp_count;
  logic          resp_ovf;

  accum_multi #(.p_width(W), .p_max_nmsgs(MX)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_last(req_last),
    .cfg_op(cfg_op), .cfg_nmsgs(cfg_nmsgs),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .resp_count(resp_count), .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    int          n;
    int          len;
    logic [7:0]  msgs [8];
    bit          last_end;
    logic [7:0]  exp_msg;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;

  // Drive one complete group with resp_rdy low, check the response one cycle
  // after the closing handshake, then consume it.
  task automatic run_group(input vec_t v, input string tag);
    resp_rdy = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      req_val   = 1'b1;
      req_msg   = v.msgs[i];
      req_last  = v.last_end && (i == v.len - 1);
      cfg_op    = v.op;
      cfg_nmsgs = CW'(v.n);
      @(negedge clk);
      check({tag, "_req_rdy"}, int'(req_rdy), 1);
      step();
    end
    req_val  = 1'b0;
    req_last = 1'b0;
    check({tag, "_resp_val"}, int'(resp_val), 1);
    check({tag, "_resp_msg"}, int'(resp_msg), int'(v.exp_msg));
    check({tag, "_resp_count"}, int'(resp_count), v.exp_cnt);
    check({tag, "_resp_ovf"}, int'(resp_ovf), int'(v.exp_ovf));
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    check({tag, "_resp_gone"}, int'(resp_val), 0);
  endtask

  // ---------------- behavioural scoreboard for the random phase ----------------
  typedef struct { int msg; int cnt; int ovf; } exp_t;
  exp_t     exp_q [$];
  int       g_msgs [$];
  int       g_op, g_n;
  bit       sb_en = 1'b0;

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reduce a whole group from the operator rules: sums use the true total,
  // max/min use signed interpretation.
  function automatic exp_t reduce_group();
    exp_t r;
    int total = 0;
    int best  = to_signed8(g_msgs[0]);
    foreach (g_msgs[i]) begin
      total += g_msgs[i];
      if (g_op == 1 && to_signed8(g_msgs[i]) > best) best = to_signed8(g_msgs[i]);
      if (g_op == 2 && to_signed8(g_msgs[i]) < best) best = to_signed8(g_msgs[i]);
    end
    r.cnt = g_msgs.size();
    case (g_op)
      0: begin r.msg = total % 256;             r.ovf = (total > 255); end
      3: begin r.msg = (total > 255) ? 255 : total; r.ovf = (total > 255); end
      default: begin r.msg = best & 8'hFF;      r.ovf = 0; end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb_en) begin
      if (resp_val && resp_rdy) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_msg", int'(resp_msg), e.msg);
          check("sb_count", int'(resp_count), e.cnt);
          check("sb_ovf", int'(resp_ovf), e.ovf);
        end
      end
      if (req_val && req_rdy) begin
        if (g_msgs.size() == 0) begin
          g_op = int'(cfg_op);
          g_n  = (cfg_nmsgs == 0) ? 1 : ((int'(cfg_nmsgs) > MX) ? MX : int'(cfg_nmsgs));
        end
        g_msgs.push_back(int'(req_msg));
        if (g_msgs.size() == g_n || req_last) begin
          exp_q.push_back(reduce_group());
          g_msgs.delete();
        end
      end
    end
  end

  vec_t tbl [11];

  initial begin
    // op, n, len, msgs, last_end, exp_msg, exp_cnt, exp_ovf
    tbl[0]  = '{2'b00, 4,  4, '{8'h80,8'h40,8'h40,8'h01,0,0,0,0}, 0, 8'h01, 4, 1};
    tbl[1]  = '{2'b11, 3,  3, '{8'hF0,8'h20,8'h01,0,0,0,0,0},     0, 8'hFF, 3, 1};
    tbl[2]  = '{2'b01, 3,  3, '{8'h7F,8'h80,8'h05,0,0,0,0,0},     0, 8'h7F, 3, 0};
    tbl[3]  = '{2'b10, 3,  3, '{8'h7F,8'h80,8'h05,0,0,0,0,0},     0, 8'h80, 3, 0};
    tbl[4]  = '{2'b00, 8,  3, '{8'h01,8'h02,8'h03,0,0,0,0,0},     1, 8'h06, 3, 0};
    tbl[5]  = '{2'b00, 0,  1, '{8'h09,0,0,0,0,0,0,0},             0, 8'h09, 1, 0};
    tbl[6]  = '{2'b00, 15, 8, '{8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10}, 0, 8'h80, 8, 0};
    tbl[7]  = '{2'b10, 4,  4, '{8'h10,8'hFF,8'h80,8'h7F,0,0,0,0}, 0, 8'h80, 4, 0};
    tbl[8]  = '{2'b11, 2,  2, '{8'hFE,8'h01,0,0,0,0,0,0},         0, 8'hFF, 2, 0};
    tbl[9]  = '{2'b00, 5,  1, '{8'hAA,0,0,0,0,0,0,0},             1, 8'hAA, 1, 0};
    tbl[10] = '{2'b01, 2,  2, '{8'hFF,8'hFE,0,0,0,0,0,0},         0, 8'hFF, 2, 0};

    reset = 1'b1; req_val = 1'b0; req_msg = '0; req_last = 1'b0;
    cfg_op = 2'b00; cfg_nmsgs = '0; resp_rdy = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_req_rdy", int'(req_rdy), 1);
    check("rst_resp_val", int'(resp_val), 0);
    check("rst_resp_msg", int'(resp_msg), 0);
    check("rst_resp_count", int'(resp_count), 0);
    check("rst_resp_ovf", int'(resp_ovf), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_resp_val", int'(resp_val), 0);
    end

    foreach (tbl[i]) run_group(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: hold the result for 5 cycles with the next group waiting.
    req_val = 1'b1; cfg_op = 2'b00; cfg_nmsgs = CW'(2); req_msg = 8'h03; step();
    req_msg = 8'h04; step();
    req_msg = 8'h10;
    for (int i = 0; i < 5; i++) begin
      check("bp_req_rdy", int'(req_rdy), 0);
      check("bp_resp_val", int'(resp_val), 1);
      check("bp_resp_msg", int'(resp_msg), 8'h07);
      check("bp_resp_count", int'(resp_count), 2);
      step();
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_req_rdy", int'(req_rdy), 1);
    step();
    check("bp_next_open_resp_val", int'(resp_val), 0);
    req_msg = 8'h20; resp_rdy = 1'b0;
    step();
    req_val = 1'b0;
    check("bp_next_resp_val", int'(resp_val), 1);
    check("bp_next_resp_msg", int'(resp_msg), 8'h30);
    check("bp_next_resp_count", int'(resp_count), 2);
    resp_rdy = 1'b1; step(); resp_rdy = 1'b0;

    // Reset in the middle of an open group.
    req_val = 1'b1; cfg_op = 2'b00; cfg_nmsgs = CW'(4); req_msg = 8'h01; step();
    step();
    req_val = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    check("midrst_resp_val", int'(resp_val), 0);
    check("midrst_req_rdy", int'(req_rdy), 1);
    begin
      vec_t v;
      v = '{2'b00, 4, 4, '{8'h01,8'h01,8'h01,8'h01,0,0,0,0}, 0, 8'h04, 4, 0};
      run_group(v, "midrst_group");
    end

    // Random traffic against the behavioural scoreboard.
    reset = 1'b1; step(); reset = 1'b0;
    sb_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      req_val   = ($urandom_range(0, 3) != 0);
      req_msg   = W'($urandom_range(0, 255));
      req_last  = ($urandom_range(0, 6) == 0);
      cfg_op    = 2'($urandom_range(0, 3));
      cfg_nmsgs = CW'($urandom_range(0, 15));
      resp_rdy  = ($urandom_range(0, 9) < 7);
      step();
    end
    req_val = 1'b0; req_last = 1'b0; resp_rdy = 1'b1;
    for (int c = 0; c < 4; c++) step();
    sb_en = 1'b0;
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_multi.md
# accum_multi

Parametrised multi-mode reduction unit with val/rdy request and response interfaces. It collects a group of 1 to `p_max_nmsgs` messages and reduces them with a per-group selectable operator: wrapping add, saturating add, signed max or signed min. It returns one response per group, carrying the result, the message count and an overflow flag. It supersedes the fixed-count, add-only accumulator in CGRA test datapaths and supports early group termination and back-to-back groups.

## Interface
- `p_width`, 16, data width of messages and result
- `p_max_nmsgs`, 8, maximum group size (≥1)
- `p_cnt_width`, `$clog2(p_max_nmsgs+1)`, derived; never overridden
- `clk` input 1 — sole clock
- `reset` input 1 — synchronous, active-high
- `req_val` input 1 — request valid
- `req_rdy` output 1 — request ready
- `req_msg` input `p_width` — operand
- `req_last` input 1 — closes the current group after this message
- `cfg_op` input 2 — operator: 00 wrapping add, 01 signed max, 10 signed min, 11 unsigned saturating add
- `cfg_nmsgs` input `p_cnt_width` — group size
- `resp_val` output 1 — result valid
- `resp_rdy` input 1 — result ready
- `resp_msg` output `p_width` — reduced result
- `resp_count` output `p_cnt_width` — messages reduced into `resp_msg`
- `resp_ovf` output 1 — overflow occurred in the group

One clock; reset is synchronous and active-high.

## Operation
- Handshakes: `req_go = req_val & req_rdy`; `resp_go = resp_val & resp_rdy`.
- States:
  - IDLE: no group open.
  - ACCUM: group open, `count` in 1..n-1.
  - DONE: result held, `resp_val = 1`.
- First message of a group is a `req_go` in IDLE, or in DONE together with `resp_go`. On it:
  - Latch `cfg_op`.
  - Latch `n = cfg_nmsgs`. 0 is treated as 1; values above `p_max_nmsgs` are clamped to `p_max_nmsgs`.
  - Set `acc <= req_msg`, `count <= 1`, `ovf <= 0`.
  - `cfg_*` are ignored on all other messages.
- Later messages (`req_go` in ACCUM):
  - Set `acc <= op(acc, req_msg)` and `count <= count + 1`.
  - Op 00: sum is taken mod 2^p_width; `ovf |= carry-out`.
  - Op 11: unsigned sum clamps to all-ones; `ovf |= clamp`.
  - Ops 01/10: signed compare; on ties `acc` keeps its value; `ovf` is unchanged.
- Group close: the group closes on the `req_go` where the new `count == n` or `req_last = 1`. The next state is DONE. A 1-message group goes IDLE→DONE directly.
- Otherwise `req_go` moves IDLE→ACCUM, and ACCUM stays in ACCUM.
- DONE outputs: `resp_msg = acc`, `resp_count = count`, `resp_ovf = ovf`. These are registered and stable while `resp_val & !resp_rdy`.
- DONE exits:
  - `resp_go` without `req_go` → IDLE.
  - `resp_go` with `req_go` → new first message; the next state is ACCUM, or DONE if that message also closes its group.
- `req_rdy = !(state == DONE) | resp_rdy`. In DONE, `req_rdy` is combinationally dependent on `resp_rdy`. `resp_val` depends only on state.
- `reset` asserted at any point abandons any open group and discards any held result. No response is issued for the abandoned group.

## Timing
- Reset values:
  - `req_rdy = 1`, `resp_val = 0`, `resp_msg = 0`, `resp_count = 0`, `resp_ovf = 0`.
  - State is IDLE.
- Latency: `resp_val` rises exactly 1 cycle after the closing `req_go`.
- Throughput: one message per cycle. Groups run back-to-back with zero bubbles when `resp_rdy = 1`.
- Back-pressure: while `resp_val & !resp_rdy`, `req_rdy = 0` and no state or output changes.
- `req_last` and `count == n` in the same cycle produce a single close.
- `req_last` on a first message closes a 1-message group.
- Counter width `p_cnt_width` holds `p_max_nmsgs` without wrap.

## Test plan
All scenarios use `p_width = 8`, `p_max_nmsgs = 8`.

- **Reset:** hold `reset` 2 cycles → `req_rdy = 1` and all `resp_*` = 0; no `resp_val` for 10 idle cycles.
- **Add wrap:**
  - Stimulus: op 00, n = 4, msgs 0x80, 0x40, 0x40, 0x01.
  - Response: `resp_msg = 0x01`, `count = 4`, `ovf = 1`; `resp_val` 1 cycle after the 4th handshake.
- **Saturate / max / min:**
  - Op 11, n = 3, msgs 0xF0, 0x20, 0x01 → `resp_msg = 0xFF`, `ovf = 1`.
  - Op 01, msgs 0x7F, 0x80, 0x05 → 0x7F.
  - Op 10 on the same msgs → 0x80, `ovf = 0`.
- **Early close and n clamp:**
  - Op 00, n = 8, msgs 1, 2, 3 with `req_last` on 3 → `resp_msg = 6`, `count = 3`.
  - `cfg_nmsgs = 0`, msg 9 → single-message response 9, `count = 1`.
- **Back-pressure and pipelining:**
  - Hold `resp_rdy = 0` for 5 cycles in DONE → `req_rdy = 0` and outputs stable.
  - Raise `resp_rdy` together with `req_val` for the next group → both handshakes occur that cycle; the next group's result is correct with no bubble.
- **Reset mid-group:** 2 messages into an n = 4 group, pulse `reset` → IDLE. The next 4-message group 1, 1, 1, 1 yields 4, not 6.
